// File: rtl/fc_argmax.sv
// fc_argmax -- final classification stage of the MNIST pipeline.
//
// Consumes the serial stream of NUM_CLASSES signed class scores from fc_layer,
// tracks the running maximum (lowest index wins ties) and reports the winning
// class index one cycle after finish_fc.
//
// Optional feature macro: FC_ARGMAX_MARGIN_EN
//   When defined, the second-best score is tracked and margin = best - second
//   is reported alongside digit_out.
//
// Ports:
//   clk               in   single rising-edge clock
//   reset_n           in   asynchronous active-low reset
//   start_fc          in   clears and arms the block (highest priority)
//   predict_out       in   signed class score, DATA_WIDTH bits
//   predict_out_valid in   score qualifier, classes arrive in order 0..N-1
//   finish_fc         in   end of score stream
//   digit_out         out  index of the maximum score
//   max_score         out  maximum score (signed)
//   digit_valid       out  one-cycle result strobe
//   busy              out  high while collecting or reporting
//   count_error       out  sticky: score count differed from NUM_CLASSES
//   margin            out  best - second, DATA_WIDTH+1 bits (macro only)
module fc_argmax #(
   parameter int NUM_CLASSES = 10,
   parameter int DATA_WIDTH  = 16,
   parameter int IDX_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start_fc,
   input  logic [DATA_WIDTH-1:0] predict_out,
   input  logic                  predict_out_valid,
   input  logic                  finish_fc,
   output logic [IDX_WIDTH-1:0]  digit_out,
   output logic [DATA_WIDTH-1:0] max_score,
   output logic                  digit_valid,
   output logic                  busy,
   output logic                  count_error
`ifdef FC_ARGMAX_MARGIN_EN
   ,
   output logic [DATA_WIDTH:0]   margin
`endif
);

   // Counter must be able to hold NUM_CLASSES itself (saturation value).
   localparam int            CW   = $clog2(NUM_CLASSES + 1);
   localparam logic [CW-1:0] FULL = CW'(NUM_CLASSES);

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]                cnt, cnt_nxt;
   logic signed [DATA_WIDTH-1:0] best, best_nxt, score;
   logic [IDX_WIDTH-1:0]         best_idx, idx_nxt;
   logic                         take, accept, overflow, fin, short_err;
`ifdef FC_ARGMAX_MARGIN_EN
   logic signed [DATA_WIDTH-1:0] second, second_nxt;
   logic signed [DATA_WIDTH:0]   best_x, second_x;
   logic [DATA_WIDTH:0]          margin_nxt;
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (start_fc) begin
         state_nxt = COLLECT;
      end else begin
         case (state)
            COLLECT: if (finish_fc) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign digit_valid = (state == DONE);
   assign busy        = (state != IDLE);

   // ---------------- score qualification ----------------
   assign score     = $signed(predict_out);
   assign take      = (state == COLLECT) && predict_out_valid && !start_fc;
   assign accept    = take && (cnt != FULL);
   assign overflow  = take && (cnt == FULL);
   assign cnt_nxt   = cnt + CW'(accept);
   assign fin       = (state == COLLECT) && finish_fc && !start_fc;
   // Same-cycle score is counted before the length check.
   assign short_err = fin && (cnt_nxt != FULL);

   // Next best/second including this cycle's score, so a score arriving
   // together with finish_fc lands in the reported result.
   always_comb begin
      best_nxt   = best;
      idx_nxt    = best_idx;
`ifdef FC_ARGMAX_MARGIN_EN
      second_nxt = second;
`endif
      if (accept) begin
         if (cnt == '0) begin
            best_nxt = score;
            idx_nxt  = '0;
         end else if (score > best) begin
`ifdef FC_ARGMAX_MARGIN_EN
            second_nxt = best;
`endif
            best_nxt   = score;
            idx_nxt    = IDX_WIDTH'(cnt);
         end
`ifdef FC_ARGMAX_MARGIN_EN
         // Second score seeds the runner-up unconditionally (unless it is
         // the new best); afterwards only a strictly larger score replaces it.
         else if (cnt == CW'(1) || score > second) begin
            second_nxt = score;
         end
`endif
      end
   end

`ifdef FC_ARGMAX_MARGIN_EN
   assign best_x     = best_nxt;
   assign second_x   = second_nxt;
   assign margin_nxt = (cnt_nxt >= CW'(2)) ? DATA_WIDTH'(0) + (best_x - second_x)
                                           : '0;
`endif

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt         <= '0;
         best        <= '0;
         best_idx    <= '0;
         count_error <= 1'b0;
         digit_out   <= '0;
         max_score   <= '0;
`ifdef FC_ARGMAX_MARGIN_EN
         second      <= '0;
         margin      <= '0;
`endif
      end else if (start_fc) begin
         cnt         <= '0;
         best        <= '0;
         best_idx    <= '0;
         count_error <= 1'b0;
         digit_out   <= '0;
         max_score   <= '0;
`ifdef FC_ARGMAX_MARGIN_EN
         second      <= '0;
         margin      <= '0;
`endif
      end else begin
         cnt      <= cnt_nxt;
         best     <= best_nxt;
         best_idx <= idx_nxt;
`ifdef FC_ARGMAX_MARGIN_EN
         second   <= second_nxt;
`endif
         if (overflow || short_err) count_error <= 1'b1;
         if (fin) begin
            digit_out <= idx_nxt;
            max_score <= best_nxt;
`ifdef FC_ARGMAX_MARGIN_EN
            margin    <= margin_nxt;
`endif
         end
      end
   end

endmodule

// File: tb/tb_fc_argmax.sv
// Scoreboard bench for fc_argmax: the driver pushes the expected result
// (computed from the raw list of scores sent) when finish_fc is issued; a
// forked monitor pops and compares on every digit_valid.
module tb_fc_argmax;
   localparam int N  = 10;
   localparam int DW = 16;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start_fc = 1'b0;
   logic [DW-1:0] predict_out = '0;
   logic          predict_out_valid = 1'b0;
   logic          finish_fc = 1'b0;
   logic [IW-1:0] digit_out;
   logic [DW-1:0] max_score;
   logic          digit_valid, busy, count_error;
`ifdef FC_ARGMAX_MARGIN_EN
   logic [DW:0]   margin;
`endif

   typedef struct {
      int digit;
      int maxv;
      int err;
      int marg;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   sent[$];
   int   stim[$];
   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fc_argmax #(.NUM_CLASSES(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
      .clk(clk), .reset_n(reset_n), .start_fc(start_fc),
      .predict_out(predict_out), .predict_out_valid(predict_out_valid),
      .finish_fc(finish_fc), .digit_out(digit_out), .max_score(max_score),
      .digit_valid(digit_valid), .busy(busy), .count_error(count_error)
`ifdef FC_ARGMAX_MARGIN_EN
      , .margin(margin)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reference: argmax over the first N scores (lowest index on ties),
   // runner-up = largest of the remaining scores.
   function automatic exp_t model();
      exp_t e;
      int   n = sent.size();
      int   k = (n < N) ? n : N;
      int   sec;
      e.err = (n != N) ? 1 : 0;
      e.digit = 0; e.maxv = 0; e.marg = 0; e.cyc = 0;
      for (int i = 0; i < k; i++)
         if (i == 0 || sent[i] > e.maxv) begin
            e.maxv = sent[i];
            e.digit = i;
         end
      if (k >= 2) begin
         sec = -(1 << 30);
         for (int i = 0; i < k; i++)
            if (i != e.digit && sent[i] > sec) sec = sent[i];
         e.marg = e.maxv - sec;
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start_fc = 1'b1;
      sent.delete();
      tick();
      start_fc = 1'b0;
   endtask

   task automatic send(input int s);
      predict_out = 16'(s);
      predict_out_valid = 1'b1;
      sent.push_back(s);
      tick();
      predict_out_valid = 1'b0;
   endtask

   task automatic fin(input bit with_score, input int s);
      exp_t e;
      if (with_score) begin
         predict_out = 16'(s);
         predict_out_valid = 1'b1;
         sent.push_back(s);
      end
      finish_fc = 1'b1;
      e = model();
      e.cyc = cyc + 1;
      sb.push_back(e);
      tick();
      finish_fc = 1'b0;
      predict_out_valid = 1'b0;
   endtask

   // Full inference from stim; optionally the last score rides with finish.
   task automatic play(input bit same, input bit gaps);
      int last;
      do_start();
      last = (same && stim.size() > 0) ? stim.size() - 1 : stim.size();
      for (int i = 0; i < last; i++) begin
         send(stim[i]);
         if (gaps) repeat ($urandom_range(0, 2)) tick();
      end
      if (same && stim.size() > 0) fin(1'b1, stim[last]);
      else                         fin(1'b0, 0);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n && digit_valid) begin
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL spurious_digit_valid actual=1 expected=0");
            end else begin
               e = sb.pop_front();
               chk("dv_cycle", cyc, e.cyc);
               chk("digit_out", int'(digit_out), e.digit);
               chk("max_score", int'($signed(max_score)), e.maxv);
               chk("count_error", int'(count_error), e.err);
`ifdef FC_ARGMAX_MARGIN_EN
               chk("margin", int'(margin), e.marg);
`endif
            end
         end
      end
   endtask

   initial begin
      logic [15:0] r;
      int          n;
      fork monitor(); join_none

      // reset state
      #12;
      chk("rst_digit", int'(digit_out), 0);
      chk("rst_max", int'(max_score), 0);
      chk("rst_dv", int'(digit_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_err", int'(count_error), 0);
      @(posedge clk); #1 reset_n = 1'b1;
      tick();

      // nominal stream
      stim = '{3, -7, 12, 0, 5, 9, -1, 4, 2, 8};
      play(1'b0, 1'b0);
      tick();
      chk("busy_after_dv", int'(busy), 0);
      repeat (2) tick();

      // all ties
      stim = '{-100, -100, -100, -100, -100, -100, -100, -100, -100, -100};
      play(1'b0, 1'b1); repeat (3) tick();

      // extremes
      stim = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, 32767};
      play(1'b0, 1'b0); repeat (3) tick();

      // short stream
      stim = '{1, 2, 3, 4, 5, 6, 7};
      play(1'b0, 1'b0); repeat (3) tick();

      // long stream: 11th score ignored but flags the error at once
      do_start();
      chk("busy_after_start", int'(busy), 1);
      for (int i = 0; i < 10; i++) send(i);
      chk("err_before_11th", int'(count_error), 0);
      send(99);
      chk("err_after_11th", int'(count_error), 1);
      fin(1'b0, 0); repeat (3) tick();

      // last score together with finish
      stim = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 50};
      play(1'b1, 1'b0); repeat (3) tick();

      // abort after 4 scores, then a full stream
      do_start();
      for (int i = 0; i < 4; i++) send(100 + i);
      stim = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
      play(1'b0, 1'b0); repeat (3) tick();

      // reset mid-stream
      do_start();
      for (int i = 0; i < 3; i++) send(40 + i);
      reset_n = 1'b0;
      #2;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_digit", int'(digit_out), 0);
      chk("midrst_max", int'(max_score), 0);
      chk("midrst_err", int'(count_error), 0);
      tick();
      reset_n = 1'b1;
      tick();

      // scores and finish while idle are ignored
      predict_out = 16'd77; predict_out_valid = 1'b1; finish_fc = 1'b1;
      repeat (2) tick();
      predict_out_valid = 1'b0; finish_fc = 1'b0;
      tick();
      chk("idle_busy", int'(busy), 0);

      // zero scores
      do_start();
      fin(1'b0, 0); repeat (3) tick();

      // back-to-back: second start lands on the digit_valid cycle
      stim = '{5, 1, 5, 2, 0, 0, 0, 0, 0, 3};
      play(1'b0, 1'b0);
      stim = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, 0};
      play(1'b0, 1'b0); repeat (3) tick();

      // randomized inferences
      for (int t = 0; t < 40; t++) begin
         n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : N;
         stim.delete();
         for (int i = 0; i < n; i++) begin
            if (t % 2 == 0) stim.push_back(int'($urandom_range(0, 8)) - 4);
            else begin
               r = 16'($urandom);
               stim.push_back(int'($signed(r)));
            end
         end
         play(1'($urandom_range(0, 1)), 1'b1);
         if ($urandom_range(0, 3) != 0) repeat ($urandom_range(1, 3)) tick();
      end

      repeat (5) tick();
      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
